// File: rtl/syscall_unit_pkg.sv
// Shared CPU definitions for the SYSCALL service unit: FSM encoding, syscall codes,
// ASCII constants and a nibble selector used by the hex printer.
package cpu_defs;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HEX    = 3'd1;
    localparam logic [2:0] ST_CHAR   = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    localparam logic [31:0] CODE_EXIT       = 32'd10;
    localparam logic [31:0] CODE_PRINT_CHAR = 32'd11;
    localparam logic [31:0] CODE_PRINT_HEX  = 32'd34;

    localparam logic [7:0] ASCII_ZERO       = 8'h30;
    localparam logic [7:0] ASCII_HEX_A_BIAS = 8'h57;
    localparam logic [7:0] ASCII_NEWLINE    = 8'h0A;

    // Index 0 is the most significant nibble; indices past 7 have no digit.
    function automatic logic [3:0] nibble_at(input logic [31:0] word, input logic [3:0] idx);
        case (idx)
            4'd0:    return word[31:28];
            4'd1:    return word[27:24];
            4'd2:    return word[23:20];
            4'd3:    return word[19:16];
            4'd4:    return word[15:12];
            4'd5:    return word[11:8];
            4'd6:    return word[7:4];
            4'd7:    return word[3:0];
            default: return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/syscall_unit_hex2ascii.sv
// Combinational conversion of one 4-bit value to its lowercase ASCII hex digit.
module hex2ascii
    import cpu_defs::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    // Digits 0-9 map from '0', digits a-f map from 'a' minus ten.
    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = ASCII_ZERO + {4'h0, nibble_i};
        end else begin
            ascii_o = ASCII_HEX_A_BIAS + {4'h0, nibble_i};
        end
    end

endmodule

// File: rtl/syscall_unit.sv
// SYSCALL service unit: decodes $v0, streams console bytes over valid/ready while
// stalling the front end, counts accepted syscalls and halts the core on exit.
module syscall_unit
    import cpu_defs::*;
#(
    parameter logic HEX_NEWLINE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall_valid,
    input  logic [31:0] v0_data,
    input  logic [31:0] a0_data,
    input  logic [31:0] pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        stall,
    output logic        halt,
    output logic        bad_syscall,
    output logic [15:0] syscall_count
);

    localparam logic [3:0] LAST_IDX = HEX_NEWLINE ? 4'd8 : 4'd7;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] arg_q, arg_d;
    logic [15:0] count_q, count_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        halt_q, halt_d;
    logic        bad_q, bad_d;
    logic        stall_s;
    logic [3:0]  nib_s;
    logic [7:0]  ascii_s;
    logic [3:0]  cnt_nxt_s;
    logic        unused_pc_s;

    // The trace address is not needed by the datapath.
    assign unused_pc_s = ^pc;
    assign cnt_nxt_s   = cnt_q + 4'd1;

    hex2ascii u_hex2ascii (
        .nibble_i (nib_s),
        .ascii_o  (ascii_s)
    );

    // Next-state, byte preload and combinational stall decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        arg_d       = arg_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        halt_d      = halt_q;
        bad_d       = 1'b0;
        stall_s     = 1'b0;
        nib_s       = 4'h0;
        case (state_q)
            ST_IDLE: begin
                if (syscall_valid) begin
                    arg_d   = a0_data;
                    count_d = count_q + 16'd1;
                    case (v0_data)
                        CODE_PRINT_HEX: begin
                            state_d     = ST_HEX;
                            cnt_d       = 4'd0;
                            nib_s       = a0_data[31:28];
                            out_valid_d = 1'b1;
                            out_data_d  = ascii_s;
                            stall_s     = 1'b1;
                        end
                        CODE_PRINT_CHAR: begin
                            state_d     = ST_CHAR;
                            out_valid_d = 1'b1;
                            out_data_d  = a0_data[7:0];
                            stall_s     = 1'b1;
                        end
                        CODE_EXIT: begin
                            state_d = ST_HALTED;
                            halt_d  = 1'b1;
                            stall_s = 1'b1;
                        end
                        default: begin
                            bad_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HEX: begin
                stall_s = 1'b1;
                // Preload the following byte so out_data changes only on a handshake.
                if (out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b0;
                        out_data_d  = 8'h00;
                    end else begin
                        cnt_d = cnt_nxt_s;
                        nib_s = nibble_at(arg_q, cnt_nxt_s);
                        if (cnt_nxt_s == 4'd8) begin
                            out_data_d = ASCII_NEWLINE;
                        end else begin
                            out_data_d = ascii_s;
                        end
                    end
                end else begin
                    state_d = ST_HEX;
                end
            end
            ST_CHAR: begin
                stall_s = 1'b1;
                if (out_ready) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b0;
                    out_data_d  = 8'h00;
                end else begin
                    state_d = ST_CHAR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_HALTED: begin
                stall_s = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_data_d  = 8'h00;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            arg_q       <= 32'h0000_0000;
            count_q     <= 16'h0000;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            halt_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            arg_q       <= arg_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            halt_q      <= halt_d;
            bad_q       <= bad_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign stall         = stall_s;
    assign halt          = halt_q;
    assign bad_syscall   = bad_q;
    assign syscall_count = count_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: hex/char printing, bad codes, counter wrap,
// reset mid-transfer and the sticky halt.
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        syscall_valid;
    logic [31:0] v0_data;
    logic [31:0] a0_data;
    logic [31:0] pc;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        stall;
    logic        halt;
    logic        bad_syscall;
    logic [15:0] syscall_count;

    int total = 0;
    int bad   = 0;

    syscall_unit dut (
        .clk           (clk),
        .rst           (rst),
        .syscall_valid (syscall_valid),
        .v0_data       (v0_data),
        .a0_data       (a0_data),
        .pc            (pc),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .stall         (stall),
        .halt          (halt),
        .bad_syscall   (bad_syscall),
        .syscall_count (syscall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".out_data"}, {24'd0, out_data}, 32'd0);
        chk({tag, ".halt"}, {31'd0, halt}, 32'd0);
        chk({tag, ".bad"}, {31'd0, bad_syscall}, 32'd0);
        chk({tag, ".count"}, {16'd0, syscall_count}, 32'd0);
        chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
    endtask

    // Issue print-hex with ready held high and check all 9 bytes plus DONE.
    task automatic run_hex(input string tag, input logic [31:0] arg, input logic [71:0] exp_bytes);
        syscall_valid = 1'b1;
        v0_data       = 32'd34;
        a0_data       = arg;
        out_ready     = 1'b1;
        #1;
        chk({tag, ".accept_stall"}, {31'd0, stall}, 32'd1);
        step();
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s.valid%0d", tag, i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("%s.byte%0d", tag, i), {24'd0, out_data}, {24'd0, exp_bytes[71-8*i -: 8]});
            chk($sformatf("%s.stall%0d", tag, i), {31'd0, stall}, 32'd1);
            step();
        end
        chk({tag, ".done_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, ".done_valid"}, {31'd0, out_valid}, 32'd0);
        syscall_valid = 1'b0;
        out_ready     = 1'b0;
        step();
    endtask

    initial begin
        rst           = 1'b0;
        syscall_valid = 1'b0;
        v0_data       = 32'd0;
        a0_data       = 32'd0;
        pc            = 32'h0040_0000;
        out_ready     = 1'b0;
        #1;
        chk_reset_outputs("reset");
        step();
        rst = 1'b1;
        step();
        chk_reset_outputs("post_reset");

        // 1. print hex DEADBEEF with newline
        run_hex("hex1", 32'hDEADBEEF, 72'h64_65_61_64_62_65_65_66_0A);
        chk("hex1.count", {16'd0, syscall_count}, 32'd1);

        // 2. print char with ready 0,0,1
        syscall_valid = 1'b1;
        v0_data       = 32'd11;
        a0_data       = 32'h0000_0141;
        out_ready     = 1'b0;
        #1;
        chk("char.accept_stall", {31'd0, stall}, 32'd1);
        step();
        chk("char.c1_valid", {31'd0, out_valid}, 32'd1);
        chk("char.c1_data", {24'd0, out_data}, 32'h41);
        chk("char.c1_stall", {31'd0, stall}, 32'd1);
        step();
        chk("char.c2_data", {24'd0, out_data}, 32'h41);
        chk("char.c2_stall", {31'd0, stall}, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("char.c3_data", {24'd0, out_data}, 32'h41);
        chk("char.c3_stall", {31'd0, stall}, 32'd1);
        step();
        chk("char.done_valid", {31'd0, out_valid}, 32'd0);
        chk("char.done_stall", {31'd0, stall}, 32'd0);
        chk("char.done_count", {16'd0, syscall_count}, 32'd2);
        syscall_valid = 1'b0;
        out_ready     = 1'b0;
        step();

        // 4. unsupported code, then print char next cycle
        syscall_valid = 1'b1;
        v0_data       = 32'd5;
        #1;
        chk("bad.stall", {31'd0, stall}, 32'd0);
        step();
        chk("bad.pulse", {31'd0, bad_syscall}, 32'd1);
        chk("bad.count", {16'd0, syscall_count}, 32'd3);
        v0_data = 32'd11;
        a0_data = 32'h0000_005A;
        #1;
        chk("bad.next_stall", {31'd0, stall}, 32'd1);
        step();
        chk("bad.pulse_end", {31'd0, bad_syscall}, 32'd0);
        chk("bad.next_count", {16'd0, syscall_count}, 32'd4);
        chk("bad.next_data", {24'd0, out_data}, 32'h5A);
        out_ready = 1'b1;
        step();
        chk("bad.next_done", {31'd0, out_valid}, 32'd0);
        syscall_valid = 1'b0;
        out_ready     = 1'b0;
        step();

        // 5. reset during the third hex byte
        syscall_valid = 1'b1;
        v0_data       = 32'd34;
        a0_data       = 32'h0123ABCD;
        out_ready     = 1'b1;
        step();
        chk("abort.b0", {24'd0, out_data}, 32'h30);
        step();
        chk("abort.b1", {24'd0, out_data}, 32'h31);
        step();
        chk("abort.b2", {24'd0, out_data}, 32'h32);
        chk("abort.b2_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst           = 1'b0;
        syscall_valid = 1'b0;
        out_ready     = 1'b0;
        #1;
        chk_reset_outputs("abort");
        step();
        rst = 1'b1;
        step();
        chk("abort.idle_valid", {31'd0, out_valid}, 32'd0);
        run_hex("hex2", 32'h0123ABCD, 72'h30_31_32_33_61_62_63_64_0A);
        chk("hex2.count", {16'd0, syscall_count}, 32'd1);

        // 6. counter wrap through back-to-back unsupported codes
        syscall_valid = 1'b1;
        v0_data       = 32'd5;
        for (int i = 0; i < 65534; i++) begin
            step();
        end
        chk("wrap.ffff", {16'd0, syscall_count}, 32'h0000FFFF);
        chk("wrap.bad_held", {31'd0, bad_syscall}, 32'd1);
        step();
        chk("wrap.zero", {16'd0, syscall_count}, 32'd0);
        syscall_valid = 1'b0;
        step();
        chk("wrap.bad_clear", {31'd0, bad_syscall}, 32'd0);

        // 3. exit halts until reset
        syscall_valid = 1'b1;
        v0_data       = 32'd10;
        #1;
        chk("halt.accept_stall", {31'd0, stall}, 32'd1);
        chk("halt.accept_halt", {31'd0, halt}, 32'd0);
        step();
        chk("halt.halt", {31'd0, halt}, 32'd1);
        chk("halt.stall", {31'd0, stall}, 32'd1);
        chk("halt.count", {16'd0, syscall_count}, 32'd1);
        v0_data   = 32'd34;
        out_ready = 1'b1;
        step();
        step();
        chk("halt.ignore_halt", {31'd0, halt}, 32'd1);
        chk("halt.ignore_valid", {31'd0, out_valid}, 32'd0);
        chk("halt.ignore_count", {16'd0, syscall_count}, 32'd1);
        chk("halt.ignore_stall", {31'd0, stall}, 32'd1);
        rst           = 1'b0;
        syscall_valid = 1'b0;
        out_ready     = 1'b0;
        #1;
        chk_reset_outputs("halt_rst");
        step();
        rst = 1'b1;
        step();
        chk_reset_outputs("halt_release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
